// File: rtl/spmv_fifo_pkg.sv
// Shared sizing helper and default thresholds for the SpMV FIFOs.
package spmv_fifo_pkg;
  localparam int DEF_ALMOST_FULL_COUNT  = 1;
  localparam int DEF_ALMOST_EMPTY_COUNT = 1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/spmv_fifo_ram.sv
// Simple dual-port DEPTHxWIDTH memory: synchronous write, registered read.
module spmv_fifo_ram
  import spmv_fifo_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      re,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write when waddr == raddr (full FIFO push+pop returns old head).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/spmv_std_fifo.sv
// Single-clock FIFO with registered q, count and registered almost flags.
// Define SPMV_STD_FIFO_CHECK_EN to compile simulation overflow/underflow checks.
module spmv_std_fifo
  import spmv_fifo_pkg::*;
#(
  parameter int WIDTH              = 64,
  parameter int DEPTH              = 32,
  parameter int ALMOST_FULL_COUNT  = DEF_ALMOST_FULL_COUNT,
  parameter int ALMOST_EMPTY_COUNT = DEF_ALMOST_EMPTY_COUNT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       d,
  output logic [WIDTH-1:0]       q,
  output logic                   full,
  output logic                   empty,
  output logic [ptr_w(DEPTH):0]  count,
  output logic                   almost_empty,
  output logic                   almost_full
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic AF_RST = (DEPTH - ALMOST_FULL_COUNT <= 0);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_next;
  logic          do_push, do_pop;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)      count_next = count + CW'(1);
    else if (!do_push && do_pop) count_next = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= AF_RST;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (int'(count_next) == DEPTH);
      almost_empty <= (int'(count_next) <= ALMOST_EMPTY_COUNT);
      almost_full  <= (int'(count_next) >= DEPTH - ALMOST_FULL_COUNT);
    end
  end

  spmv_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata (d),
    .re    (do_pop),
    .raddr (rd_ptr),
    .rdata (q)
  );

`ifdef SPMV_STD_FIFO_CHECK_EN
  always @(posedge clk) begin
    if (rst && push && full && !pop)
      $error("%m: overflow, push dropped at %0t, count=%0d", $time, count);
    if (rst && pop && empty)
      $error("%m: underflow, pop ignored at %0t, count=%0d", $time, count);
  end
`endif
endmodule

// File: tb/tb_spmv_std_fifo.sv
// Randomised + directed bench for spmv_std_fifo against a queue-based model.
module tb_spmv_std_fifo;
  localparam int W = 8, D = 4, AFC = 1, AEC = 1;

  logic         clk = 0, rst = 1, push = 0, pop = 0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q;
  logic         full, empty, almost_empty, almost_full;
  logic [2:0]   count;

  int checks = 0, errors = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] mq_q = '0;

  spmv_std_fifo #(.WIDTH(W), .DEPTH(D), .ALMOST_FULL_COUNT(AFC), .ALMOST_EMPTY_COUNT(AEC)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .d(d), .q(q),
    .full(full), .empty(empty), .count(count),
    .almost_empty(almost_empty), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model-based compare on every falling edge; outputs settled since the rising edge.
  always @(negedge clk) begin
    chk("q", int'(q), int'(mq_q));
    chk("count", int'(count), mq.size());
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("full", int'(full), int'(mq.size() == D));
    chk("almost_empty", int'(almost_empty), int'(mq.size() <= AEC));
    chk("almost_full", int'(almost_full), int'(mq.size() >= D - AFC));
  end

  // Drive one cycle, apply the FIFO rules to the model at the edge, return past the next falling edge.
  task automatic cyc(input bit p, input bit pp, input logic [W-1:0] dd);
    bit acc_push, acc_pop;
    push = p; pop = pp; d = dd;
    @(posedge clk);
    acc_pop  = pp && mq.size() > 0;
    acc_push = p && (mq.size() < D || pp);
    if (acc_pop)  mq_q = mq.pop_front();
    if (acc_push) mq.push_back(dd);
    @(negedge clk); #1;
    push = 0; pop = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    mq.delete();
    mq_q = '0;
  endtask

  initial begin
    #1 do_reset();
    @(negedge clk); @(negedge clk); #1;
    rst = 1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_q", int'(q), 0);

    // Fill to full, then overflow.
    cyc(1, 0, 8'h11); cyc(1, 0, 8'h22); cyc(1, 0, 8'h33);
    chk("af_at_3", int'(almost_full), 1);
    chk("full_at_3", int'(full), 0);
    cyc(1, 0, 8'h44);
    chk("full_at_4", int'(full), 1);
    chk("count_at_4", int'(count), 4);
    cyc(1, 0, 8'h55);
    chk("overflow_count", int'(count), 4);

    // Drain in order, then underflow.
    cyc(0, 1, 0); chk("pop1", int'(q), 8'h11);
    cyc(0, 1, 0); chk("pop2", int'(q), 8'h22);
    cyc(0, 1, 0); chk("pop3", int'(q), 8'h33);
    cyc(0, 1, 0); chk("pop4", int'(q), 8'h44);
    chk("drained_empty", int'(empty), 1);
    cyc(0, 1, 0); chk("underflow_q", int'(q), 8'h44);

    // Push+pop on empty: no fall-through.
    cyc(1, 1, 8'hAA);
    chk("pp_empty_count", int'(count), 1);
    chk("pp_empty_q", int'(q), 8'h44);
    cyc(0, 1, 0); chk("pp_empty_next", int'(q), 8'hAA);

    // Push+pop on full, then wrap-around pairs.
    cyc(1, 0, 8'h11); cyc(1, 0, 8'h22); cyc(1, 0, 8'h33); cyc(1, 0, 8'h44);
    cyc(1, 1, 8'h66);
    chk("pp_full_q", int'(q), 8'h11);
    chk("pp_full_count", int'(count), 4);
    cyc(1, 1, 8'h77); chk("pp_full_q2", int'(q), 8'h22);
    for (int i = 0; i < 9; i++) cyc(1, 1, W'($urandom));

    // Down to two entries, then streaming push+pop.
    cyc(0, 1, 0); cyc(0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, W'($urandom));
      chk("stream_count", int'(count), 2);
    end

    // Asynchronous reset with three entries held.
    cyc(1, 0, 8'h5A);
    chk("pre_rst_count", int'(count), 3);
    do_reset();
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_full", int'(full), 0);
    chk("arst_ae", int'(almost_empty), 1);
    chk("arst_af", int'(almost_full), 0);
    chk("arst_q", int'(q), 0);
    @(negedge clk); #1;
    rst = 1;

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 100) < 55, ($urandom % 100) < 45, W'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
